// File: rtl/avg_hex_display_pkg.sv
// ---------------------------------------------------------------------------
// avg_hex_display_pkg
// Shared definitions for the signed-sample seven-segment display path:
//   - active-low segment constants (bit0 = a ... bit6 = g)
//   - FSM state encoding for the double-dabble conversion engine
//   - BCD digit count and small helpers for the decoder and the engine
// ---------------------------------------------------------------------------
package avg_hex_display_pkg;

    // Three BCD digits cover the full magnitude range of an 8-bit signed
    // sample (0..128).
    localparam int BCD_DIGITS = 3;

    // Active-low segment patterns.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Conversion engine states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Map a BCD nibble to its segment pattern. Codes 10..15 can never be
    // produced by a correct conversion, so they simply show as blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[digit];
    endfunction

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the next doubling, so 3 is added first to carry into the next digit.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        if (nibble >= 4'd5) begin
            return nibble + 4'd3;
        end
        return nibble;
    endfunction

endpackage

// File: rtl/avg_hex_display_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Ports:
//   bcd_i    in   4  BCD digit 0..9
//   blank_i  in   1  1 = force all segments off (leading-zero blanking)
//   seg_o    out  7  active-low segments, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module seg7_decode
    import avg_hex_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blanking takes priority so the caller can suppress leading zeros
    // without having to gate the digit value itself.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = seg_encode(bcd_i);
        end
    end

endmodule

// File: rtl/avg_hex_display.sv
// ---------------------------------------------------------------------------
// avg_hex_display
// Downstream stage of the FIR / moving-average path. Takes the signed filter
// output, converts it to sign plus three decimal digits with a sequential
// double-dabble engine (one iteration per clock) and drives four active-low
// seven-segment displays. Display commits are spaced by at least RATE_DIV
// clocks so values remain readable at board clock speed.
//
// Parameters:
//   WIDTH           sample width; only 8 is supported (3 BCD digits)
//   RATE_DIV        minimum clocks between two display commits
// Ports:
//   Clk             in   1  system clock, all state on posedge
//   Reset           in   1  asynchronous, active-high
//   sample_valid    in   1  one-cycle strobe, sample carries a new value
//   sample          in   8  signed two's-complement filter output
//   display_enable  in   1  1 = show value, 0 = all segments off
//   busy            out  1  conversion in progress (CONVERT or COMMIT)
//   done            out  1  one-cycle pulse when the HEX registers update
//   HEX0..HEX3      out  7  active-low segments; HEX0 = units, HEX3 = sign
// ---------------------------------------------------------------------------
module avg_hex_display
    import avg_hex_display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RATE_DIV = 25_000_000
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             display_enable,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    // Shift register layout is {hundreds, tens, units, magnitude}.
    localparam int SHIFT_W = BCD_DIGITS * 4 + WIDTH;
    localparam int TIMER_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RATE_DIV - 1);
    localparam logic [2:0]         LAST_ITER    = 3'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [2:0]           iter_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_d;
    logic                 sign_q;
    logic [WIDTH-1:0]     pending_q;
    logic                 pending_v_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 busy_q;
    logic                 done_q;
    logic [6:0]           hex0_q;
    logic [6:0]           hex1_q;
    logic [6:0]           hex2_q;
    logic [6:0]           hex3_q;

    logic [WIDTH-1:0]     mag;
    logic [SHIFT_W-1:0]   adjusted;
    logic [3:0]           digit_hund;
    logic [3:0]           digit_tens;
    logic [3:0]           digit_units;
    logic                 blank_hund;
    logic                 blank_tens;
    logic [6:0]           seg_hund;
    logic [6:0]           seg_tens;
    logic [6:0]           seg_units;

    // Magnitude of the pending sample. The two's-complement negation of
    // -128 yields 8'h80, which read as unsigned is exactly 128, so the
    // magnitude fits the unsigned WIDTH-bit field without a ninth bit.
    always_comb begin
        mag = pending_q;
        if (pending_q[WIDTH-1]) begin
            mag = (~pending_q) + WIDTH'(1);
        end
    end

    // One double-dabble iteration: correct every BCD nibble that would
    // overflow on doubling, then shift the whole {bcd, magnitude} word left.
    always_comb begin
        adjusted = shift_q;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            adjusted[WIDTH + 4*k +: 4] = dabble_adjust(shift_q[WIDTH + 4*k +: 4]);
        end
        shift_d = adjusted << 1;
    end

    // Digit extraction and leading-zero blanking. The tens digit is only
    // blank when the hundreds digit is also zero; units are always shown.
    always_comb begin
        digit_units = shift_q[WIDTH     +: 4];
        digit_tens  = shift_q[WIDTH + 4 +: 4];
        digit_hund  = shift_q[WIDTH + 8 +: 4];
        blank_hund  = (digit_hund == 4'd0);
        blank_tens  = blank_hund && (digit_tens == 4'd0);
    end

    seg7_decode u_dec_units (
        .bcd_i   (digit_units),
        .blank_i (1'b0),
        .seg_o   (seg_units)
    );

    seg7_decode u_dec_tens (
        .bcd_i   (digit_tens),
        .blank_i (blank_tens),
        .seg_o   (seg_tens)
    );

    seg7_decode u_dec_hund (
        .bcd_i   (digit_hund),
        .blank_i (blank_hund),
        .seg_o   (seg_hund)
    );

    // Main sequencer: input capture, hold timer, conversion FSM and the
    // registered display/status outputs all live here.
    //
    // A strobe is always captured, whatever the FSM is doing, so a sample
    // arriving during a conversion or hold window overwrites any older
    // waiting one and only the newest is shown once the timer has run out.
    // When a new strobe coincides with the IDLE launch, the launch consumes
    // the older value and the new one stays pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            iter_q      <= 3'd0;
            shift_q     <= '0;
            sign_q      <= 1'b0;
            pending_q   <= '0;
            pending_v_q <= 1'b0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hex0_q      <= SEG_DIGIT[0];
            hex1_q      <= SEG_BLANK;
            hex2_q      <= SEG_BLANK;
            hex3_q      <= SEG_BLANK;
        end else begin
            done_q <= 1'b0;

            if (timer_q != '0) begin
                timer_q <= timer_q - TIMER_W'(1);
            end

            if (sample_valid) begin
                pending_q   <= sample;
                pending_v_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pending_v_q && (timer_q == '0)) begin
                        shift_q <= {{(BCD_DIGITS*4){1'b0}}, mag};
                        sign_q  <= pending_q[WIDTH-1];
                        iter_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONVERT;
                        if (!sample_valid) begin
                            pending_v_q <= 1'b0;
                        end
                    end
                end

                ST_CONVERT: begin
                    shift_q <= shift_d;
                    iter_q  <= iter_q + 3'd1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    hex0_q  <= seg_units;
                    hex1_q  <= seg_tens;
                    hex2_q  <= seg_hund;
                    hex3_q  <= sign_q ? SEG_MINUS : SEG_BLANK;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    timer_q <= TIMER_RELOAD;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Blanking only masks the outputs; the committed value is kept so that
    // re-enabling shows it again without a new conversion.
    always_comb begin
        HEX0 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX2 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        if (display_enable) begin
            HEX0 = hex0_q;
            HEX1 = hex1_q;
            HEX2 = hex2_q;
            HEX3 = hex3_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_avg_hex_display.sv
// ---------------------------------------------------------------------------
// tb_avg_hex_display
// Self-checking bench for avg_hex_display with RATE_DIV = 16.
// ---------------------------------------------------------------------------
module tb_avg_hex_display;

    localparam int RATE_DIV = 16;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] SEG_REF [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int          value;
        logic [27:0] expHex;
    } vector_t;

    logic       Clk;
    logic       Reset;
    logic       sampleValid;
    logic [7:0] sample;
    logic       displayEnable;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int assertCount = 0;
    int failCount   = 0;

    logic [27:0] doneLog[$];

    avg_hex_display #(.WIDTH(8), .RATE_DIV(RATE_DIV)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .sample_valid   (sampleValid),
        .sample         (sample),
        .display_enable (displayEnable),
        .busy           (busy),
        .done           (done),
        .HEX0           (HEX0),
        .HEX1           (HEX1),
        .HEX2           (HEX2),
        .HEX3           (HEX3)
    );

    // 100 MHz style clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Record what the display shows on every done pulse.
    always @(negedge Clk) begin
        if (done) begin
            doneLog.push_back({HEX3, HEX2, HEX1, HEX0});
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected display for a signed value, worked out with decimal arithmetic.
    function automatic logic [27:0] modelHex(input int v);
        int m;
        int h;
        int t;
        int u;
        logic [6:0] h3, h2, h1, h0;
        m  = (v < 0) ? -v : v;
        h  = m / 100;
        t  = (m / 10) % 10;
        u  = m % 10;
        h3 = (v < 0) ? MN : BL;
        h2 = (h == 0) ? BL : SEG_REF[h];
        h1 = (h == 0 && t == 0) ? BL : SEG_REF[t];
        h0 = SEG_REF[u];
        return {h3, h2, h1, h0};
    endfunction

    function automatic logic [27:0] hexNow();
        return {HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe one sample; returns 1 ns after the capturing edge.
    task automatic applyStimulus(input int v);
        @(posedge Clk);
        #1;
        sample      = 8'(v);
        sampleValid = 1'b1;
        @(posedge Clk);
        #1;
        sampleValid = 1'b0;
    endtask

    // Wait (bounded) until the done log reaches the given size.
    task automatic waitForDone(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (doneLog.size() < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        #1;
        assertCount++;
        if (doneLog.size() < target) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d done pulses expected %0d", name, doneLog.size(), target);
        end
    endtask

    // Single sample with an idle engine: exact 10-cycle latency check.
    task automatic runIsolated(input int v, input logic [27:0] exp, input string name);
        int base;
        base = doneLog.size();
        applyStimulus(v);
        repeat (9) @(posedge Clk);
        #1;
        checkOutput({name, " done@N+9"}, 28'(done), 28'(0));
        checkOutput({name, " busy@N+9"}, 28'(busy), 28'(1));
        @(posedge Clk);
        #1;
        checkOutput({name, " hex@N+10"}, hexNow(), exp);
        checkOutput({name, " done@N+10"}, 28'(done), 28'(1));
        checkOutput({name, " busy@N+10"}, 28'(busy), 28'(0));
        repeat (20) @(posedge Clk);
        #1;
        checkOutput({name, " pulses"}, 28'(doneLog.size() - base), 28'(1));
    endtask

    // Several strobes inside one conversion/hold window: only the first and
    // the newest values are ever shown.
    task automatic runBurst(input int vals[$], input string name);
        int base;
        base = doneLog.size();
        applyStimulus(vals[0]);
        for (int i = 1; i < vals.size(); i++) begin
            repeat ($urandom_range(0, 1)) @(posedge Clk);
            applyStimulus(vals[i]);
        end
        waitForDone(base + 2, 80, {name, " wait"});
        if (doneLog.size() >= base + 2) begin
            checkOutput({name, " first"}, doneLog[base], modelHex(vals[0]));
            checkOutput({name, " last"}, doneLog[base + 1], modelHex(vals[vals.size() - 1]));
        end
        repeat (30) @(posedge Clk);
        #1;
        checkOutput({name, " pulses"}, 28'(doneLog.size() - base), 28'(2));
    endtask

    initial begin
        vector_t vectors[8];
        int      burstVals[$];
        int      base;
        logic signed [7:0] r;

        vectors[0] = '{57,   {BL, BL, 7'b0010010, 7'b1111000}};
        vectors[1] = '{0,    {BL, BL, BL, 7'b1000000}};
        vectors[2] = '{127,  {BL, 7'b1111001, 7'b0100100, 7'b1111000}};
        vectors[3] = '{-5,   {MN, BL, BL, 7'b0010010}};
        vectors[4] = '{100,  {BL, 7'b1111001, 7'b1000000, 7'b1000000}};
        vectors[5] = '{-90,  {MN, BL, 7'b0010000, 7'b1000000}};
        vectors[6] = '{10,   {BL, BL, 7'b1111001, 7'b1000000}};
        vectors[7] = '{-128, {MN, 7'b1111001, 7'b0100100, 7'b0000000}};

        Reset         = 1'b1;
        sampleValid   = 1'b0;
        sample        = 8'd0;
        displayEnable = 1'b1;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset hex", hexNow(), {BL, BL, BL, 7'b1000000});
        checkOutput("reset busy", 28'(busy), 28'(0));
        checkOutput("reset done", 28'(done), 28'(0));
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("post-reset hex", hexNow(), {BL, BL, BL, 7'b1000000});

        // Table-driven isolated conversions, ending with -128.
        for (int i = 0; i < 8; i++) begin
            runIsolated(vectors[i].value, vectors[i].expHex, $sformatf("vec%0d(%0d)", i, vectors[i].value));
        end

        // Display blanking keeps the committed value.
        base = doneLog.size();
        displayEnable = 1'b0;
        #1;
        checkOutput("disabled hex", hexNow(), {BL, BL, BL, BL});
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("disabled hold", hexNow(), {BL, BL, BL, BL});
        displayEnable = 1'b1;
        #1;
        checkOutput("reenabled hex", hexNow(), {MN, 7'b1111001, 7'b0100100, 7'b0000000});
        repeat (20) @(posedge Clk);
        #1;
        checkOutput("reenable no done", 28'(doneLog.size() - base), 28'(0));

        // Conversion still commits while the display is off.
        displayEnable = 1'b0;
        applyStimulus(33);
        waitForDone(base + 1, 30, "disabled commit");
        displayEnable = 1'b1;
        #1;
        checkOutput("shown after disabled commit", hexNow(), modelHex(33));
        repeat (20) @(posedge Clk);

        // Reset during CONVERT iteration 4 of +127.
        base = doneLog.size();
        applyStimulus(127);
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("midconv busy", 28'(busy), 28'(1));
        Reset = 1'b1;
        #1;
        checkOutput("midconv reset hex", hexNow(), {BL, BL, BL, 7'b1000000});
        checkOutput("midconv reset busy", 28'(busy), 28'(0));
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (30) @(posedge Clk);
        #1;
        checkOutput("midconv no done", 28'(doneLog.size() - base), 28'(0));
        checkOutput("midconv hex stays", hexNow(), {BL, BL, BL, 7'b1000000});
        checkOutput("midconv busy idle", 28'(busy), 28'(0));

        // Samples inside the hold window: only 9 and then 0 are shown.
        burstVals = '{9, -5, 100, 0};
        runBurst(burstVals, "burst9");

        // Randomised isolated samples against the decimal model.
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom_range(0, 255));
            runIsolated(int'(r), modelHex(int'(r)), $sformatf("rand%0d(%0d)", i, r));
        end

        // Randomised bursts.
        for (int b = 0; b < 5; b++) begin
            burstVals.delete();
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                r = 8'($urandom_range(0, 255));
                burstVals.push_back(int'(r));
            end
            runBurst(burstVals, $sformatf("rburst%0d", b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
